// File: rtl/icon_sprite_loader_pkg.sv
// Shared definitions for the icon sprite loader: orientation and pixel codes,
// sprite geometry, loader FSM states and the sprite address helper.
package icon_sprite_loader_pkg;

  localparam int unsigned ICON_DIM      = 16;
  localparam int unsigned SPRITE_ADDR_W = 11;

  // Orientation frame codes, matching botinfo[2:0]
  typedef enum logic [2:0] {
    ORIENT_N  = 3'd0,
    ORIENT_NE = 3'd1,
    ORIENT_E  = 3'd2,
    ORIENT_SE = 3'd3,
    ORIENT_S  = 3'd4,
    ORIENT_SW = 3'd5,
    ORIENT_W  = 3'd6,
    ORIENT_NW = 3'd7
  } orient_e;

  localparam logic [1:0] PIX_TRANSPARENT = 2'b00;

  // Column index of the last pixel in a packed word
  localparam logic [3:0] LAST_PIX = 4'(ICON_DIM - 1);

  typedef enum logic [0:0] {
    StIdle,
    StUnpack
  } loader_state_e;

  // Frame-local sprite address: plain concatenation, no wrap between frames
  function automatic logic [SPRITE_ADDR_W-1:0] sprite_addr(input logic [2:0] orient,
                                                           input logic [3:0] row,
                                                           input logic [3:0] col);
    return {orient, row, col};
  endfunction

endpackage

// File: rtl/icon_sprite_loader_sprite_ram.sv
// Simple dual-port sprite RAM: one write port, one registered read-first read
// port. With two banks the bank select is the top address bit.
module icon_sprite_loader_sprite_ram
  import icon_sprite_loader_pkg::*;
#(
  parameter int unsigned NumBanks   = 1,
  parameter int unsigned FrameAddrW = SPRITE_ADDR_W,
  localparam int unsigned BankW     = (NumBanks > 1) ? 1 : 0,
  localparam int unsigned AddrW     = FrameAddrW + BankW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [1:0]       wr_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [1:0]       rd_data
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [1:0] r_mem [Depth];
  logic [1:0] r_rd_data;

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; sampling before the write lands gives read-first behaviour
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= PIX_TRANSPARENT;
    end else begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/icon_sprite_loader.sv
// Icon sprite loader: unpacks 32-bit sprite words into sixteen 2-bit pixels,
// one per cycle, into the sprite RAM read by the icon renderer.
// Optional double buffering is enabled with `define ICON_SPRITE_DBUF_EN.
module icon_sprite_loader
  import icon_sprite_loader_pkg::*;
#(
  parameter int unsigned NUM_ORIENT    = 8,
  parameter int unsigned PIX_PER_FRAME = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [2:0]  wr_orient,
  input  logic [3:0]  wr_row,
  output logic        wr_ready,
  output logic        drop_err,
  input  logic        err_clr,
  output logic        row_done,
  input  logic        commit,
  input  logic        vsync_tick,
  output logic        front_bank,
  input  logic [2:0]  rd_orient,
  input  logic [7:0]  rd_idx,
  output logic [1:0]  rd_pix
);

  localparam int unsigned FrameAddrW = $clog2(NUM_ORIENT) + $clog2(PIX_PER_FRAME);
`ifdef ICON_SPRITE_DBUF_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif
  localparam int unsigned RamAddrW = FrameAddrW + ((NumBanks > 1) ? 1 : 0);

  loader_state_e r_state, w_state_d;
  logic [31:0]   r_shift;
  logic [2:0]    r_orient;
  logic [3:0]    r_row;
  logic [3:0]    r_pix_cnt;
  logic          r_row_done, w_row_done_d;
  logic          r_drop_err;
  logic          w_ram_we;
  logic          w_accept;
  logic [RamAddrW-1:0] w_wr_addr;
  logic [RamAddrW-1:0] w_rd_addr;

  // FSM next-state and decoded outputs
  always_comb begin
    w_state_d    = r_state;
    wr_ready     = 1'b0;
    w_ram_we     = 1'b0;
    w_row_done_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        wr_ready = 1'b1;
        if (wr_en) begin
          w_state_d = StUnpack;
        end
      end
      StUnpack: begin
        w_ram_we = 1'b1;
        if (r_pix_cnt == LAST_PIX) begin
          w_state_d    = StIdle;
          w_row_done_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_accept = (r_state == StIdle) && wr_en;

  // FSM state, pixel counter, row_done pulse and sticky drop error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pix_cnt  <= '0;
      r_row_done <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_row_done <= w_row_done_d;
      if (w_accept) begin
        r_pix_cnt <= '0;
      end else if (r_state == StUnpack) begin
        r_pix_cnt <= r_pix_cnt + 4'd1;
      end
      // A drop in the same cycle as err_clr keeps the error set
      if (wr_en && (r_state == StUnpack)) begin
        r_drop_err <= 1'b1;
      end else if (err_clr) begin
        r_drop_err <= 1'b0;
      end
    end
  end

  // Word latch and unpacking shifter
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift  <= wr_data;
      r_orient <= wr_orient;
      r_row    <= wr_row;
    end else if (r_state == StUnpack) begin
      r_shift <= {2'b00, r_shift[31:2]};
    end
  end

`ifdef ICON_SPRITE_DBUF_EN
  logic r_front_bank;
  logic r_swap_pending;

  // Bank swap: only at a frame boundary and never mid-word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_front_bank   <= 1'b0;
      r_swap_pending <= 1'b0;
    end else begin
      if (vsync_tick && r_swap_pending && (r_state == StIdle)) begin
        r_front_bank   <= ~r_front_bank;
        r_swap_pending <= 1'b0;
      end
      // A commit arriving with vsync waits for the following vsync
      if (commit) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign front_bank = r_front_bank;
  assign w_wr_addr  = {~r_front_bank, sprite_addr(r_orient, r_row, r_pix_cnt)};
  assign w_rd_addr  = {r_front_bank, rd_orient, rd_idx};
`else
  logic w_unused_dbuf;

  assign w_unused_dbuf = ^{commit, vsync_tick};
  assign front_bank    = 1'b0;
  assign w_wr_addr     = sprite_addr(r_orient, r_row, r_pix_cnt);
  assign w_rd_addr     = {rd_orient, rd_idx};
`endif

  icon_sprite_loader_sprite_ram #(
    .NumBanks  (NumBanks),
    .FrameAddrW(FrameAddrW)
  ) u_sprite_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    // Gating with rst_n aborts a word cleanly when reset lands mid-unpack
    .wr_en  (w_ram_we & rst_n),
    .wr_addr(w_wr_addr),
    .wr_data(r_shift[1:0]),
    .rd_addr(w_rd_addr),
    .rd_data(rd_pix)
  );

  assign drop_err = r_drop_err;
  assign row_done = r_row_done;

endmodule

// File: tb/tb_icon_sprite_loader.sv
// Self-checking bench for icon_sprite_loader. Read results are checked through
// a scoreboard fed from a reference model of the sprite RAM banks.
module tb_icon_sprite_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [2:0]  wr_orient = '0;
  logic [3:0]  wr_row = '0;
  logic        wr_ready;
  logic        drop_err;
  logic        err_clr = 1'b0;
  logic        row_done;
  logic        commit = 1'b0;
  logic        vsync_tick = 1'b0;
  logic        front_bank;
  logic [2:0]  rd_orient = '0;
  logic [7:0]  rd_idx = '0;
  logic [1:0]  rd_pix;

  icon_sprite_loader #(
    .NUM_ORIENT   (8),
    .PIX_PER_FRAME(256)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_orient (wr_orient),
    .wr_row    (wr_row),
    .wr_ready  (wr_ready),
    .drop_err  (drop_err),
    .err_clr   (err_clr),
    .row_done  (row_done),
    .commit    (commit),
    .vsync_tick(vsync_tick),
    .front_bank(front_bank),
    .rd_orient (rd_orient),
    .rd_idx    (rd_idx),
    .rd_pix    (rd_pix)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // Reference RAM model: [bank][address]
  logic [1:0] mdl [2][2048];
  bit         mdl_front = 1'b0;

  // Read scoreboard
  logic [1:0] exp_q [$];
  string      tag_q [$];
  logic       rd_vld = 1'b0;
  logic       rd_vld_q = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rd_vld_q <= rd_vld;

  // Pop and compare one read result per cycle, half a cycle after it is registered
  always @(negedge clk) begin
    if (rd_vld_q) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [1:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, {30'd0, rd_pix}, {30'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit wbank();
`ifdef ICON_SPRITE_DBUF_EN
    return ~mdl_front;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit rbank();
`ifdef ICON_SPRITE_DBUF_EN
    return mdl_front;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int addr_of(input int o, input int r, input int c);
    return o * 256 + r * 16 + c;
  endfunction

  function automatic logic [31:0] pat(input int seed, input int o, input int r);
    return (32'(seed * 4096 + o * 16 + r + 1) * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [31:0] get_word(input bit b, input int o, input int r);
    logic [31:0] w;
    for (int k = 0; k < 16; k++) w[2*k +: 2] = mdl[b][addr_of(o, r, k)];
    return w;
  endfunction

  task automatic model_write(input bit b, input int o, input int r, input logic [31:0] d);
    for (int k = 0; k < 16; k++) mdl[b][addr_of(o, r, k)] = d[2*k +: 2];
  endtask

  task automatic issue_read(input int o, input int idx, input logic [1:0] e, input string tag);
    rd_orient = 3'(o);
    rd_idx    = 8'(idx);
    rd_vld    = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tick();
  endtask

  task automatic end_reads();
    rd_vld = 1'b0;
    tick();
  endtask

  // Full word write; with chk the handshake timing is verified as well
  task automatic write_word(input int o, input int r, input logic [31:0] d, input bit chk);
    bit b;
    b = wbank();
    wr_en     = 1'b1;
    wr_data   = d;
    wr_orient = 3'(o);
    wr_row    = 4'(r);
    tick();
    wr_en = 1'b0;
    if (chk) check_eq("busy_after_accept", wr_ready, 1'b0);
    repeat (15) tick();
    if (chk) check_eq("row_done_not_early", row_done, 1'b0);
    tick();
    if (chk) begin
      check_eq("row_done_pulse", row_done, 1'b1);
      check_eq("ready_with_row_done", wr_ready, 1'b1);
    end
    tick();
    if (chk) check_eq("row_done_one_cycle", row_done, 1'b0);
    model_write(b, o, r, d);
  endtask

  // Make the back bank visible (double-buffer build only)
  task automatic publish();
`ifdef ICON_SPRITE_DBUF_EN
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    check_eq("no_swap_before_vsync", front_bank, mdl_front);
    vsync_tick = 1'b1;
    tick();
    vsync_tick = 1'b0;
    mdl_front = ~mdl_front;
    check_eq("swap_at_vsync", front_bank, mdl_front);
`endif
  endtask

  task automatic fill(input int seed);
    for (int o = 0; o < 8; o++) begin
      for (int r = 0; r < 16; r++) write_word(o, r, pat(seed, o, r), 1'b0);
    end
  endtask

  initial begin
    bit          b;
    logic [31:0] nw;
    int          a;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_wr_ready", wr_ready, 1'b1);
    check_eq("rst_drop_err", drop_err, 1'b0);
    check_eq("rst_row_done", row_done, 1'b0);
    check_eq("rst_rd_pix", rd_pix, 2'b00);
    check_eq("rst_front_bank", front_bank, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic unpack order and timing
    write_word(2, 3, 32'hE4E4_E4E4, 1'b1);
    publish();
    issue_read(2, 48, 2'b00, "e4_idx48");
    issue_read(2, 49, 2'b01, "e4_idx49");
    issue_read(2, 50, 2'b10, "e4_idx50");
    issue_read(2, 51, 2'b11, "e4_idx51");
    end_reads();

    // Fill every row of every frame (both banks when double-buffered), read all back
    fill(0);
    publish();
`ifdef ICON_SPRITE_DBUF_EN
    fill(1);
    publish();
`endif
    for (int i = 0; i < 2048; i++) issue_read(i / 256, i % 256, mdl[rbank()][i], "fill_readback");
    end_reads();

    // Back-to-back strobes: second word dropped, first word intact
    b = wbank();
    wr_en = 1'b1; wr_data = 32'h1B1B_1B1B; wr_orient = 3'd5; wr_row = 4'd0;
    tick();
    wr_data = 32'hFFFF_FFFF; wr_row = 4'd1;
    tick();
    wr_en = 1'b0;
    check_eq("drop_err_set", drop_err, 1'b1);
    check_eq("drop_busy", wr_ready, 1'b0);
    repeat (15) tick();
    check_eq("drop_row_done", row_done, 1'b1);
    tick();
    model_write(b, 5, 0, 32'h1B1B_1B1B);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("err_clr", drop_err, 1'b0);

    // Drop and err_clr together: set wins
    wr_en = 1'b1; wr_data = 32'h0F0F_3C3C; wr_orient = 3'd5; wr_row = 4'd2;
    tick();
    wr_data = 32'h0; wr_row = 4'd3; err_clr = 1'b1;
    tick();
    wr_en = 1'b0; err_clr = 1'b0;
    check_eq("set_beats_clr", drop_err, 1'b1);
    repeat (16) tick();
    model_write(b, 5, 2, 32'h0F0F_3C3C);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("err_clr_again", drop_err, 1'b0);
    publish();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) issue_read(5, r * 16 + c, mdl[rbank()][addr_of(5, r, c)], "drop_rows");
    end
    end_reads();

    // Same-address read during write: old value, then new value
    b = wbank();
    a = addr_of(6, 7, 0);
    nw = ~get_word(b, 6, 7);
    wr_en = 1'b1; wr_data = nw; wr_orient = 3'd6; wr_row = 4'd7;
    tick();
    wr_en = 1'b0;
    issue_read(6, 7 * 16, mdl[rbank()][a], "rd_first_old");
    mdl[b][a] = nw[1:0];
    issue_read(6, 7 * 16, mdl[rbank()][a], "rd_first_new");
    end_reads();
    repeat (14) tick();
    model_write(b, 6, 7, nw);

    // Reset at pix_cnt=7 aborts the word after pixels 0..6
    b = wbank();
    nw = ~get_word(b, 1, 9);
    wr_en = 1'b1; wr_data = nw; wr_orient = 3'd1; wr_row = 4'd9;
    tick();
    wr_en = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    check_eq("abort_wr_ready", wr_ready, 1'b1);
    check_eq("abort_row_done", row_done, 1'b0);
    check_eq("abort_rd_pix", rd_pix, 2'b00);
    check_eq("abort_front_bank", front_bank, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) mdl[b][addr_of(1, 9, k)] = nw[2*k +: 2];
    mdl_front = 1'b0;
    tick();
    if (b != rbank()) publish();
    for (int c = 0; c < 16; c++) issue_read(1, 9 * 16 + c, mdl[rbank()][addr_of(1, 9, c)], "abort_row");
    end_reads();

`ifdef ICON_SPRITE_DBUF_EN
    // Commit and vsync during unpack: swap waits for the next vsync
    b = wbank();
    wr_en = 1'b1; wr_data = 32'hC3C3_5A5A; wr_orient = 3'd7; wr_row = 4'd15;
    tick();
    wr_en = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    vsync_tick = 1'b1;
    tick();
    vsync_tick = 1'b0;
    check_eq("defer_no_swap", front_bank, mdl_front);
    repeat (14) tick();
    model_write(b, 7, 15, 32'hC3C3_5A5A);
    check_eq("defer_still_no_swap", front_bank, mdl_front);
    vsync_tick = 1'b1;
    tick();
    vsync_tick = 1'b0;
    mdl_front = ~mdl_front;
    check_eq("defer_swap_next_vsync", front_bank, mdl_front);
    for (int c = 0; c < 16; c++) issue_read(7, 240 + c, mdl[rbank()][addr_of(7, 15, c)], "defer_row");
    end_reads();

    // Commit together with vsync: swap on the following vsync
    commit = 1'b1; vsync_tick = 1'b1;
    tick();
    commit = 1'b0; vsync_tick = 1'b0;
    check_eq("same_cycle_no_swap", front_bank, mdl_front);
    vsync_tick = 1'b1;
    tick();
    vsync_tick = 1'b0;
    mdl_front = ~mdl_front;
    check_eq("same_cycle_swap_later", front_bank, mdl_front);
`else
    // Single-bank build ignores commit/vsync
    commit = 1'b1; vsync_tick = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    vsync_tick = 1'b0;
    check_eq("single_bank_front", front_bank, 1'b0);
`endif

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
